// File: rtl/dphy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dphy_pkg
//  Description : Definitions shared by the D-PHY lane TX sequencer and the RX
//                byte synchroniser: the HS sync byte, the LP line codes and
//                the TX sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package dphy_pkg;

    // Leader sequence byte. On the wire, LSB first, it reads 0,0,0,1,1,1,0,1.
    localparam logic [7:0] SYNC_PATTERN = 8'hB8;

    // {Dp,Dn} LP line states.
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LPX   = 3'd1,
        PREP  = 3'd2,
        ZERO  = 3'd3,
        SYNC  = 3'd4,
        DATA  = 3'd5,
        TRAIL = 3'd6,
        EXIT  = 3'd7
    } tx_state_t;

endpackage : dphy_pkg
`default_nettype wire

// File: rtl/dphy_tx_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dphy_tx_timer
//  Description : Loadable 8-bit down-counter with a zero flag. Loading N makes
//                the flag rise N cycles later, so the FSM loads (duration-1)
//                and leaves the state on the cycle the flag is high.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_load        - load i_value this edge (overrides count)
//                i_value       - value to load
//                o_zero        - count register is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module dphy_tx_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_value,
    output logic       o_zero
);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 8'h00;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != 8'h00) begin
            r_count <= r_count - 8'h01;
        end
    end

    assign o_zero = (r_count == 8'h00);

endmodule : dphy_tx_timer
`default_nettype wire

// File: rtl/dphy_hs_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dphy_hs_tx_sequencer
//  Description : Byte-clock D-PHY data-lane TX sequencer. Takes one packet over
//                a valid/ready stream and drives LP-01, LP-00, HS-zero, the
//                sync byte, the payload, HS-trail and LP-11 exit.
//  Ports       : clk_i, rst_i  - byte clock, synchronous active-high reset
//                data_i        - payload byte (LSB first on the wire)
//                valid_i       - byte valid / start-of-transmission request
//                last_i        - final byte of the packet
//                ready_o       - byte taken when valid_i & ready_o
//                hs_byte_o     - byte to the serializer
//                hs_en_o       - HS driver enable
//                lp_o          - {Dp,Dn} LP levels
//                busy_o        - sequencer not in IDLE
//                underrun_o    - one-cycle pulse on payload underrun
//                pkt_cnt_o     - packets closed by last_i   (DPHY_TX_STATS_EN)
//                urun_cnt_o    - underrun count             (DPHY_TX_STATS_EN)
//  Options     : `define DPHY_TX_STATS_EN adds the two 16-bit wrap counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module dphy_hs_tx_sequencer
    import dphy_pkg::*;
#(
    parameter int T_LPX     = 2,
    parameter int T_PREPARE = 2,
    parameter int T_ZERO    = 6,
    parameter int T_TRAIL   = 4,
    parameter int T_EXIT    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    input  logic        last_i,
    output logic        ready_o,
    output logic [7:0]  hs_byte_o,
    output logic        hs_en_o,
    output logic [1:0]  lp_o,
    output logic        busy_o,
    output logic        underrun_o
`ifdef DPHY_TX_STATS_EN
    ,
    output logic [15:0] pkt_cnt_o,
    output logic [15:0] urun_cnt_o
`endif
);

    // Timer load values: a state held for N cycles is loaded with N-1.
    localparam logic [7:0] c_LPX_LD   = 8'(T_LPX - 1);
    localparam logic [7:0] c_PREP_LD  = 8'(T_PREPARE - 1);
    localparam logic [7:0] c_ZERO_LD  = 8'(T_ZERO - 1);
    localparam logic [7:0] c_TRAIL_LD = 8'(T_TRAIL - 1);
    localparam logic [7:0] c_EXIT_LD  = 8'(T_EXIT - 1);

    tx_state_t  r_state;
    tx_state_t  w_next_state;
    logic       w_load;
    logic [7:0] w_load_val;
    logic       w_zero;

    logic [7:0] r_hs_byte;
    logic       r_hs_en;
    logic [1:0] r_lp;
    logic       r_busy;
    logic       r_underrun;
    // Bit 7 of the most recent HS byte; the trail is its complement.
    logic       r_last_b7;

    dphy_tx_timer u_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_zero  (w_zero)
    );

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = 8'h00;
        case (r_state)
            IDLE: begin
                if (valid_i) begin
                    w_next_state = LPX;
                    w_load       = 1'b1;
                    w_load_val   = c_LPX_LD;
                end
            end
            LPX: begin
                if (w_zero) begin
                    w_next_state = PREP;
                    w_load       = 1'b1;
                    w_load_val   = c_PREP_LD;
                end
            end
            PREP: begin
                if (w_zero) begin
                    w_next_state = ZERO;
                    w_load       = 1'b1;
                    w_load_val   = c_ZERO_LD;
                end
            end
            ZERO: begin
                if (w_zero) begin
                    w_next_state = SYNC;
                end
            end
            SYNC: begin
                w_next_state = DATA;
            end
            DATA: begin
                // HS cannot stall: a missing byte ends the burst just like last_i.
                if (!valid_i || last_i) begin
                    w_next_state = TRAIL;
                    w_load       = 1'b1;
                    w_load_val   = c_TRAIL_LD;
                end
            end
            TRAIL: begin
                if (w_zero) begin
                    w_next_state = EXIT;
                    w_load       = 1'b1;
                    w_load_val   = c_EXIT_LD;
                end
            end
            EXIT: begin
                // A request seen here is deliberately dropped: IDLE is always
                // visited for at least one cycle.
                if (w_zero) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Line outputs are registered from the current state, so the lane shows
    // each state one cycle after the state register enters it. This keeps the
    // accepted payload (one cycle of latency) contiguous with the sync byte
    // and the trail.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_hs_byte  <= 8'h00;
            r_hs_en    <= 1'b0;
            r_lp       <= LP11;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
            r_last_b7  <= SYNC_PATTERN[7];
        end else begin
            r_state    <= w_next_state;
            r_busy     <= (w_next_state != IDLE);
            r_underrun <= 1'b0;
            r_hs_byte  <= 8'h00;
            r_hs_en    <= 1'b0;
            r_lp       <= LP11;
            case (r_state)
                IDLE: begin
                    r_lp <= LP11;
                end
                LPX: begin
                    r_lp <= LP01;
                end
                PREP: begin
                    r_lp <= LP00;
                end
                ZERO: begin
                    r_lp    <= LP00;
                    r_hs_en <= 1'b1;
                end
                SYNC: begin
                    r_lp      <= LP00;
                    r_hs_en   <= 1'b1;
                    r_hs_byte <= SYNC_PATTERN;
                    r_last_b7 <= SYNC_PATTERN[7];
                end
                DATA: begin
                    r_lp    <= LP00;
                    r_hs_en <= 1'b1;
                    if (valid_i) begin
                        r_hs_byte <= data_i;
                        r_last_b7 <= data_i[7];
                    end else begin
                        r_underrun <= 1'b1;
                        r_hs_byte  <= {8{~r_last_b7}};
                    end
                end
                TRAIL: begin
                    r_lp      <= LP00;
                    r_hs_en   <= 1'b1;
                    r_hs_byte <= {8{~r_last_b7}};
                end
                EXIT: begin
                    r_lp <= LP11;
                end
                default: begin
                    r_lp <= LP11;
                end
            endcase
        end
    end

    assign ready_o    = (r_state == DATA);
    assign hs_byte_o  = r_hs_byte;
    assign hs_en_o    = r_hs_en;
    assign lp_o       = r_lp;
    assign busy_o     = r_busy;
    assign underrun_o = r_underrun;

`ifdef DPHY_TX_STATS_EN
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_urun_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pkt_cnt  <= 16'h0000;
            r_urun_cnt <= 16'h0000;
        end else if (r_state == DATA) begin
            if (valid_i && last_i) begin
                r_pkt_cnt <= r_pkt_cnt + 16'h0001;
            end
            if (!valid_i) begin
                r_urun_cnt <= r_urun_cnt + 16'h0001;
            end
        end
    end

    assign pkt_cnt_o  = r_pkt_cnt;
    assign urun_cnt_o = r_urun_cnt;
`endif

endmodule : dphy_hs_tx_sequencer
`default_nettype wire

// File: tb/tb_dphy_hs_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dphy_hs_tx_sequencer
//  Description : Directed self-checking bench for dphy_hs_tx_sequencer with
//                default timing parameters. Trace index k is the sample taken
//                1 time unit after the k-th rising edge following stimulus
//                start.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dphy_hs_tx_sequencer;

    logic        clk;
    logic        rst_i;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        last_i;
    logic        ready_o;
    logic [7:0]  hs_byte_o;
    logic        hs_en_o;
    logic [1:0]  lp_o;
    logic        busy_o;
    logic        underrun_o;
`ifdef DPHY_TX_STATS_EN
    logic [15:0] pkt_cnt_o;
    logic [15:0] urun_cnt_o;
`endif

    int checks;
    int failures;

    logic [7:0] pkt     [0:7];
    logic [1:0] tr_lp   [0:79];
    logic       tr_en   [0:79];
    logic [7:0] tr_byte [0:79];
    logic       tr_busy [0:79];
    logic       tr_rdy  [0:79];
    logic       tr_urun [0:79];

    dphy_hs_tx_sequencer #(
        .T_LPX     (2),
        .T_PREPARE (2),
        .T_ZERO    (6),
        .T_TRAIL   (4),
        .T_EXIT    (4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .last_i     (last_i),
        .ready_o    (ready_o),
        .hs_byte_o  (hs_byte_o),
        .hs_en_o    (hs_en_o),
        .lp_o       (lp_o),
        .busy_o     (busy_o),
        .underrun_o (underrun_o)
`ifdef DPHY_TX_STATS_EN
        ,
        .pkt_cnt_o  (pkt_cnt_o),
        .urun_cnt_o (urun_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives pkt[0..nbytes-1] as npkts back-to-back packets (valid held high
    // between them), optionally dropping valid after drop_after accepted
    // bytes, and records ncyc samples into the trace arrays.
    task automatic run_packet(input int nbytes, input int drop_after,
                              input int npkts, input int ncyc);
        int   idx;
        int   done;
        logic acc;
        idx     = 0;
        done    = 0;
        data_i  = pkt[0];
        last_i  = (nbytes == 1);
        valid_i = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            acc = ready_o && valid_i;
            step();
            tr_lp[k]   = lp_o;
            tr_en[k]   = hs_en_o;
            tr_byte[k] = hs_byte_o;
            tr_busy[k] = busy_o;
            tr_rdy[k]  = ready_o;
            tr_urun[k] = underrun_o;
            if (acc) begin
                idx++;
                if (drop_after != 0 && idx == drop_after) begin
                    valid_i = 1'b0;
                    last_i  = 1'b0;
                end else if (idx == nbytes) begin
                    done++;
                    if (done < npkts) begin
                        idx    = 0;
                        data_i = pkt[0];
                        last_i = (nbytes == 1);
                    end else begin
                        valid_i = 1'b0;
                        last_i  = 1'b0;
                    end
                end else begin
                    data_i = pkt[idx];
                    last_i = (idx == nbytes - 1);
                end
            end
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        data_i  = 8'h00;
        step();
        step();
        checks++; if (hs_byte_o !== 8'h00) begin failures++; $display("FAIL reset_hs_byte got=%h exp=00", hs_byte_o); end
        checks++; if (hs_en_o !== 1'b0) begin failures++; $display("FAIL reset_hs_en got=%b exp=0", hs_en_o); end
        checks++; if (lp_o !== 2'b11) begin failures++; $display("FAIL reset_lp got=%b exp=11", lp_o); end
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (underrun_o !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun_o); end
        rst_i = 1'b0;
        step();
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_hs [0:13];
        logic [1:0] exp_lp [0:4];
        exp_hs = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB8,
                   8'h11, 8'h22, 8'h33, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        exp_lp = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
        pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
        run_packet(3, 0, 1, 26);
        for (int k = 1; k <= 5; k++) begin
            checks++; if (tr_lp[k] !== exp_lp[k-1]) begin failures++; $display("FAIL basic_lp k=%0d got=%b exp=%b", k, tr_lp[k], exp_lp[k-1]); end
            checks++; if (tr_en[k] !== 1'b0) begin failures++; $display("FAIL basic_hs_en_pre k=%0d got=%b exp=0", k, tr_en[k]); end
        end
        for (int k = 6; k <= 19; k++) begin
            checks++; if (tr_en[k] !== 1'b1) begin failures++; $display("FAIL basic_hs_en k=%0d got=%b exp=1", k, tr_en[k]); end
            checks++; if (tr_byte[k] !== exp_hs[k-6]) begin failures++; $display("FAIL basic_hs_byte k=%0d got=%h exp=%h", k, tr_byte[k], exp_hs[k-6]); end
        end
        for (int k = 20; k <= 23; k++) begin
            checks++; if (tr_lp[k] !== 2'b11 || tr_en[k] !== 1'b0) begin failures++; $display("FAIL basic_exit k=%0d got lp=%b en=%b exp lp=11 en=0", k, tr_lp[k], tr_en[k]); end
        end
        for (int k = 1; k <= 22; k++) begin
            checks++; if (tr_busy[k] !== 1'b1) begin failures++; $display("FAIL basic_busy k=%0d got=%b exp=1", k, tr_busy[k]); end
        end
        checks++; if (tr_busy[23] !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", tr_busy[23]); end
        checks++; if (tr_rdy[11] !== 1'b0) begin failures++; $display("FAIL basic_ready_pre got=%b exp=0", tr_rdy[11]); end
        for (int k = 12; k <= 14; k++) begin
            checks++; if (tr_rdy[k] !== 1'b1) begin failures++; $display("FAIL basic_ready k=%0d got=%b exp=1", k, tr_rdy[k]); end
        end
        checks++; if (tr_rdy[15] !== 1'b0) begin failures++; $display("FAIL basic_ready_post got=%b exp=0", tr_rdy[15]); end
    endtask

    task automatic test_trail_00();
        pkt[0] = 8'h5A; pkt[1] = 8'h80;
        run_packet(2, 0, 1, 24);
        checks++; if (tr_byte[13] !== 8'h5A) begin failures++; $display("FAIL t80_byte0 got=%h exp=5a", tr_byte[13]); end
        checks++; if (tr_byte[14] !== 8'h80) begin failures++; $display("FAIL t80_byte1 got=%h exp=80", tr_byte[14]); end
        for (int k = 15; k <= 18; k++) begin
            checks++; if (tr_byte[k] !== 8'h00 || tr_en[k] !== 1'b1) begin failures++; $display("FAIL t80_trail k=%0d got byte=%h en=%b exp byte=00 en=1", k, tr_byte[k], tr_en[k]); end
        end
        checks++; if (tr_en[19] !== 1'b0) begin failures++; $display("FAIL t80_hs_off got=%b exp=0", tr_en[19]); end
    endtask

    task automatic test_single_byte();
        pkt[0] = 8'h3C;
        run_packet(1, 0, 1, 24);
        checks++; if (tr_rdy[11] !== 1'b0 || tr_rdy[12] !== 1'b1 || tr_rdy[13] !== 1'b0) begin failures++; $display("FAIL single_ready got=%b%b%b exp=010", tr_rdy[11], tr_rdy[12], tr_rdy[13]); end
        checks++; if (tr_byte[13] !== 8'h3C) begin failures++; $display("FAIL single_byte got=%h exp=3c", tr_byte[13]); end
        for (int k = 14; k <= 17; k++) begin
            checks++; if (tr_byte[k] !== 8'hFF) begin failures++; $display("FAIL single_trail k=%0d got=%h exp=ff", k, tr_byte[k]); end
        end
        checks++; if (tr_en[18] !== 1'b0) begin failures++; $display("FAIL single_hs_off got=%b exp=0", tr_en[18]); end
    endtask

    task automatic test_underrun();
        int pulses;
        pkt[0] = 8'h91; pkt[1] = 8'h42; pkt[2] = 8'hC3; pkt[3] = 8'hD4; pkt[4] = 8'hE5;
        run_packet(5, 2, 1, 26);
        pulses = 0;
        for (int k = 1; k <= 26; k++) pulses += int'(tr_urun[k]);
        checks++; if (pulses != 1) begin failures++; $display("FAIL urun_pulses got=%0d exp=1", pulses); end
        checks++; if (tr_urun[15] !== 1'b1) begin failures++; $display("FAIL urun_pulse_time got=%b exp=1", tr_urun[15]); end
        checks++; if (tr_rdy[14] !== 1'b1 || tr_rdy[15] !== 1'b0) begin failures++; $display("FAIL urun_ready got=%b%b exp=10", tr_rdy[14], tr_rdy[15]); end
        checks++; if (tr_byte[13] !== 8'h91 || tr_byte[14] !== 8'h42) begin failures++; $display("FAIL urun_payload got=%h,%h exp=91,42", tr_byte[13], tr_byte[14]); end
        for (int k = 15; k <= 18; k++) begin
            checks++; if (tr_byte[k] !== 8'hFF) begin failures++; $display("FAIL urun_trail k=%0d got=%h exp=ff", k, tr_byte[k]); end
        end
        checks++; if (tr_busy[22] !== 1'b1 || tr_busy[23] !== 1'b0) begin failures++; $display("FAIL urun_busy got=%b%b exp=10", tr_busy[22], tr_busy[23]); end
    endtask

    task automatic test_reset_in_zero();
        data_i  = 8'h77;
        last_i  = 1'b1;
        valid_i = 1'b1;
        for (int k = 1; k <= 7; k++) step();
        checks++; if (hs_en_o !== 1'b1) begin failures++; $display("FAIL rz_in_zero got=%b exp=1", hs_en_o); end
        rst_i = 1'b1;
        step();
        checks++; if (hs_en_o !== 1'b0 || lp_o !== 2'b11) begin failures++; $display("FAIL rz_line got en=%b lp=%b exp en=0 lp=11", hs_en_o, lp_o); end
        checks++; if (hs_byte_o !== 8'h00 || busy_o !== 1'b0) begin failures++; $display("FAIL rz_state got byte=%h busy=%b exp byte=00 busy=0", hs_byte_o, busy_o); end
        rst_i   = 1'b0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        step();
        step();
        checks++; if (busy_o !== 1'b0 || lp_o !== 2'b11) begin failures++; $display("FAIL rz_idle got busy=%b lp=%b exp busy=0 lp=11", busy_o, lp_o); end
    endtask

    task automatic test_back_to_back();
        pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
        run_packet(3, 0, 2, 48);
        for (int k = 20; k <= 24; k++) begin
            checks++; if (tr_lp[k] !== 2'b11) begin failures++; $display("FAIL b2b_gap k=%0d got=%b exp=11", k, tr_lp[k]); end
        end
        checks++; if (tr_lp[25] !== 2'b01 || tr_lp[26] !== 2'b01) begin failures++; $display("FAIL b2b_lpx got=%b,%b exp=01,01", tr_lp[25], tr_lp[26]); end
        checks++; if (tr_busy[23] !== 1'b0 || tr_busy[24] !== 1'b1) begin failures++; $display("FAIL b2b_idle got=%b%b exp=01", tr_busy[23], tr_busy[24]); end
        for (int k = 24; k <= 34; k++) begin
            checks++; if (tr_rdy[k] !== 1'b0) begin failures++; $display("FAIL b2b_early_ready k=%0d got=%b exp=0", k, tr_rdy[k]); end
        end
        checks++; if (tr_rdy[35] !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", tr_rdy[35]); end
        checks++; if (tr_byte[35] !== 8'hB8 || tr_byte[36] !== 8'h11) begin failures++; $display("FAIL b2b_stream got=%h,%h exp=b8,11", tr_byte[35], tr_byte[36]); end
        checks++; if (tr_busy[46] !== 1'b0) begin failures++; $display("FAIL b2b_end_busy got=%b exp=0", tr_busy[46]); end
    endtask

`ifdef DPHY_TX_STATS_EN
    task automatic test_stats();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checks++; if (pkt_cnt_o !== 16'd0 || urun_cnt_o !== 16'd0) begin failures++; $display("FAIL stats_reset got=%0d,%0d exp=0,0", pkt_cnt_o, urun_cnt_o); end
        pkt[0] = 8'h3C;
        run_packet(1, 0, 3, 66);
        checks++; if (pkt_cnt_o !== 16'd3) begin failures++; $display("FAIL stats_pkt got=%0d exp=3", pkt_cnt_o); end
        pkt[0] = 8'h91; pkt[1] = 8'h42; pkt[2] = 8'hC3; pkt[3] = 8'hD4; pkt[4] = 8'hE5;
        run_packet(5, 2, 1, 26);
        checks++; if (pkt_cnt_o !== 16'd3) begin failures++; $display("FAIL stats_pkt_after_urun got=%0d exp=3", pkt_cnt_o); end
        checks++; if (urun_cnt_o !== 16'd1) begin failures++; $display("FAIL stats_urun got=%0d exp=1", urun_cnt_o); end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        last_i   = 1'b0;
        data_i   = 8'h00;
        test_reset();
        test_basic();
        test_trail_00();
        test_single_byte();
        test_underrun();
        test_reset_in_zero();
        test_back_to_back();
`ifdef DPHY_TX_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dphy_hs_tx_sequencer
`default_nettype wire
